wb_mem_slave: RTL

- Pipelined Wishbone B4 slave: the responder end of the host-command Wishbone master bus.
- Backs a word-addressed 32-bit RAM of DEPTH words with byte-lane writes.
- Inserts configurable wait states and queues up to MAX_PENDING outstanding responses, so the master sees real stall, ack and err behaviour.
- Out-of-range addresses are answered with err.

---
 rtl/wb_mem_slave_if.sv | 40 ++++
 rtl/wb_mem_slave.sv | 116 +++++++++++
 2 files changed

// File: rtl/wb_mem_slave_if.sv
// Pipelined Wishbone B4 bus between the host-command master and the memory slave.
// Clock and reset are plain module ports and are not part of this bundle.
interface wb_mem_slave_if;
    logic        i_wb_cyc;
    logic        i_wb_stb;
    logic        i_wb_we;
    logic [29:0] i_wb_addr;
    logic [31:0] i_wb_data;
    logic [3:0]  i_wb_sel;
    logic        o_wb_stall;
    logic        o_wb_ack;
    logic        o_wb_err;
    logic [31:0] o_wb_data;

    modport slave (
        input  i_wb_cyc,
        input  i_wb_stb,
        input  i_wb_we,
        input  i_wb_addr,
        input  i_wb_data,
        input  i_wb_sel,
        output o_wb_stall,
        output o_wb_ack,
        output o_wb_err,
        output o_wb_data
    );

    modport master (
        output i_wb_cyc,
        output i_wb_stb,
        output i_wb_we,
        output i_wb_addr,
        output i_wb_data,
        output i_wb_sel,
        input  o_wb_stall,
        input  o_wb_ack,
        input  o_wb_err,
        input  o_wb_data
    );
endinterface

// File: rtl/wb_mem_slave.sv
// Pipelined Wishbone B4 slave backed by a byte-writable word RAM.
// Responses wait WAIT_STATES cycles at the head of a MAX_PENDING-deep queue.
module wb_mem_slave #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0,
    parameter int MAX_PENDING = 4
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    wb_mem_slave_if.slave wb
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = $clog2(MAX_PENDING);
    localparam int CW = PW + 1;
    localparam int WW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [CW-1:0] FULL        = CW'(MAX_PENDING);
    localparam logic [WW-1:0] WAIT_RELOAD = WW'(WAIT_STATES);

    logic [31:0]   mem    [DEPTH];
    logic          q_err  [MAX_PENDING];
    logic [31:0]   q_data [MAX_PENDING];

    logic [PW-1:0] wr_ptr, wr_ptr_nxt;
    logic [PW-1:0] rd_ptr, rd_ptr_nxt;
    logic [CW-1:0] count, count_nxt;
    logic [WW-1:0] wait_cnt, wait_cnt_nxt;
    logic          stall, push, pop, in_range;
    logic [AW-1:0] mem_idx;
    logic          ack_q, err_q;
    logic [31:0]   data_q;

    assign in_range = 32'(wb.i_wb_addr) < 32'(DEPTH);
    assign mem_idx  = wb.i_wb_addr[AW-1:0];

    always_comb begin
        stall        = wb.i_wb_cyc && (count == FULL);
        push         = wb.i_wb_cyc && wb.i_wb_stb && !stall;
        pop          = wb.i_wb_cyc && (count != '0) && (wait_cnt == '0);
        count_nxt    = count;
        wait_cnt_nxt = wait_cnt;
        wr_ptr_nxt   = wr_ptr;
        rd_ptr_nxt   = rd_ptr;
        if (!wb.i_wb_cyc) begin
            // Abort: drop every pending response; accepted writes stay in RAM.
            count_nxt    = '0;
            wait_cnt_nxt = WAIT_RELOAD;
            wr_ptr_nxt   = '0;
            rd_ptr_nxt   = '0;
        end else begin
            if (push) begin
                wr_ptr_nxt = wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr_nxt   = rd_ptr + PW'(1);
                wait_cnt_nxt = WAIT_RELOAD;
            end else if ((count != '0) && (wait_cnt != '0)) begin
                wait_cnt_nxt = wait_cnt - WW'(1);
            end
            case ({push, pop})
                2'b10:   count_nxt = count + CW'(1);
                2'b01:   count_nxt = count - CW'(1);
                default: count_nxt = count;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            count    <= '0;
            wait_cnt <= WAIT_RELOAD;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            data_q   <= '0;
        end else begin
            count    <= count_nxt;
            wait_cnt <= wait_cnt_nxt;
            wr_ptr   <= wr_ptr_nxt;
            rd_ptr   <= rd_ptr_nxt;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            if (pop) begin
                ack_q  <= !q_err[rd_ptr];
                err_q  <= q_err[rd_ptr];
                data_q <= q_data[rd_ptr];
            end
        end
    end

    // RAM and queue payload are not reset; read data is captured at acceptance
    // so a read queued behind a write already sees the written value.
    always_ff @(posedge i_clk) begin
        if (push) begin
            q_err[wr_ptr]  <= !in_range;
            q_data[wr_ptr] <= (in_range && !wb.i_wb_we) ? mem[mem_idx] : '0;
            if (in_range && wb.i_wb_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (wb.i_wb_sel[b]) begin
                        mem[mem_idx][8*b +: 8] <= wb.i_wb_data[8*b +: 8];
                    end
                end
            end
        end
    end

    assign wb.o_wb_stall = stall;
    assign wb.o_wb_ack   = ack_q;
    assign wb.o_wb_err   = err_q;
    assign wb.o_wb_data  = data_q;

    a_ack_err_exclusive: assert property (@(posedge i_clk) disable iff (!i_reset_n)
        !(ack_q && err_q));
    a_count_bound: assert property (@(posedge i_clk) disable iff (!i_reset_n)
        count <= FULL);
endmodule
